// File: rtl/mux_pkg.sv
// mux_pkg: shared width constants and grant-index width helper for arb_mux_n.
package mux_pkg;
  localparam int WORD_W = 32;
  function automatic int sel_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; search starts at ptr, which moves past each winner on advance.
module rr_arbiter import mux_pkg::*; #(
  parameter int N = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);
  logic [SEL_W-1:0] ptr;
  function automatic int rot(int p, int k);
    return (p + k) % N;
  endfunction
  // scan farthest-first so the requester nearest ptr is written last and wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[rot(int'(ptr), k)]) begin
        grant = '0;
        grant[rot(int'(ptr), k)] = 1'b1;
        grant_idx = SEL_W'(rot(int'(ptr), k));
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrated mux into a one-entry registered output with valid/ready.
// ARB_MUX_RR_EN selects round-robin arbitration; otherwise fixed lowest-index priority.
module arb_mux_n import mux_pkg::*; #(
  parameter int N = 4,
  parameter int W = WORD_W,
  parameter int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             flush,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [N-1:0] grant;
  logic [SEL_W-1:0] grant_idx;
  logic [W-1:0] words [N];
  logic load_en, xfer;
  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = in_data[i*W +: W];
  end
  assign load_en = ~flush & (~out_valid | out_ready);
  assign in_ready = rst_n ? grant & {N{load_en}} : '0;
  assign xfer = |in_ready;
`ifdef ARB_MUX_RR_EN
  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(in_valid),
    .advance(xfer),
    .grant(grant),
    .grant_idx(grant_idx)
  );
`else
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (in_valid[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        grant_idx = SEL_W'(i);
      end
  end
`endif
  // xfer already excludes flush, so a flush falls through to the drain branch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= words[grant_idx];
      out_sel <= grant_idx;
    end else if (flush | out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed-vector bench with a behavioural model of arb_mux_n (N=4, W=32).
module tb_arb_mux_n;
  localparam int N = 4;
  localparam int W = 32;
`ifdef ARB_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [W-1:0] out_data;
  logic [1:0] out_sel;
  logic out_valid;
  int n_vec = 0, n_err = 0;
  int m_p = 0, m_os = 0;
  logic m_ov = 1'b0;
  logic [W-1:0] m_od = '0;
  int seq_rr [5] = '{0, 1, 2, 3, 0};
  logic [W-1:0] hold_exp;

  arb_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] word(int ch);
    return in_data[ch*W +: W];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_word(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  // called at a negedge: apply inputs, check against the model, advance the model one edge
  task automatic step(input logic [N-1:0] v, input logic r, input logic f);
    int g;
    logic [N-1:0] er;
    in_valid = v;
    out_ready = r;
    flush = f;
    #1;
    g = pick(v, RR ? m_p : 0);
    er = '0;
    if (!f && (!m_ov || r) && g >= 0) er[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("out_sel", 64'(out_sel), 64'(m_os));
    if (f) m_ov = 1'b0;
    else if (er != '0) begin
      m_ov = 1'b1;
      m_od = word(g);
      m_os = g;
      if (RR) m_p = (g + 1) % N;
    end else if (r) m_ov = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_p = 0;
    m_ov = 1'b0;
    m_od = '0;
    m_os = 0;
  endtask

  initial begin
    in_valid = 4'b1111;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_word(i, 32'h1000_0000 * (i + 1) + 32'h11);
    set_word(2, 32'hDEADBEEF);
    step(4'b0100, 1'b1, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hDEADBEEF);
    chk("single_sel", 64'(out_sel), 64'd2);
    // asynchronous reset between edges with a word held
    in_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_data", 64'(out_data), 64'd0);
    chk("async_out_sel", 64'(out_sel), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("seq_sel", 64'(out_sel), RR ? 64'(seq_rr[k]) : 64'd0);
    end
    step(4'b0100, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    chk("wrap_sel_a", 64'(out_sel), RR ? 64'd3 : 64'd0);
    step(4'b1001, 1'b1, 1'b0);
    chk("wrap_sel_b", 64'(out_sel), 64'd0);
    // backpressure: held word must survive changing inputs
    set_word(0, 32'h0A0A_0000);
    set_word(1, 32'h0B0B_0000);
    hold_exp = RR ? 32'h0B0B_0000 : 32'h0A0A_0000;
    step(4'b0011, 1'b1, 1'b0);
    set_word(0, 32'h0A0A_1111);
    set_word(1, 32'h0B0B_1111);
    for (int k = 0; k < 3; k++) begin
      step(4'b0011, 1'b0, 1'b0);
      chk("bp_data", 64'(out_data), 64'(hold_exp));
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    step(4'b0011, 1'b1, 1'b0);
    chk("bp_release_data", 64'(out_data), 64'h0A0A_1111);
    chk("bp_release_sel", 64'(out_sel), 64'd0);
    step(4'b0010, 1'b1, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(4'b0011, 1'b1, 1'b0);
    chk("post_flush_sel", 64'(out_sel), RR ? 64'd1 : 64'd0);
    step(4'b0000, 1'b1, 1'b0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N; i++) set_word(i, $urandom);
      step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
